// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and byte/word transforms for the AES-128
// inverse cipher.
//   state_t          - FSM states of aes_decrypt_top
//   ROUNDS           - number of cipher rounds (10)
//   rcon             - round constant table, index 1..10
//   sbox / inv_sbox  - S-box and inverse S-box, computed as GF(2^8) inverse
//                      plus affine map rather than stored as tables
//   rot_word, sub_word, inv_shift_rows, inv_mix_columns
// Byte 0 of a 128-bit block is bits [127:120]; column c is bytes 4c..4c+3.
package aes_pkg;

    localparam int ROUNDS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEXP,
        ST_INIT_AR,
        ST_ISR,
        ST_ISB,
        ST_KBACK,
        ST_IMC,
        ST_DONE
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Row r rotates right by r: out[r,c] = in[r,(c-r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[31 - 8*i -: 8];
            x2[i]  = xtime(a[i]);
            x4[i]  = xtime(x2[i]);
            x8[i]  = xtime(x4[i]);
            m9[i]  = x8[i] ^ a[i];
            m11[i] = x8[i] ^ x2[i] ^ a[i];
            m13[i] = x8[i] ^ x4[i] ^ a[i];
            m14[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: round-key register for the inverse cipher. The key is
// first expanded forward to round key 10, then stepped back one round key
// per inverse round, so no round keys are stored.
//   clk, rst   - clock, synchronous active-high reset
//   load       - capture key_in (cipher key)
//   expand     - apply one forward key-schedule step using rcon(rcon_idx)
//   step_back  - apply one backward step using rcon(rcon_idx)
//   rcon_idx   - round-constant index 1..10 for the current step
//   key_in     - cipher key
//   round_key  - current contents of the key register
//   back_key   - key one round earlier (combinational), valid with rcon_idx
module aes_inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         expand,
    input  logic         step_back,
    input  logic [3:0]   rcon_idx,
    input  logic [127:0] key_in,
    output logic [127:0] round_key,
    output logic [127:0] back_key
);

    logic [127:0] key_q;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  b0, b1, b2, b3;
    logic [31:0]  rc_word;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];
    assign rc_word = {rcon(rcon_idx), 24'h000000};

    // Forward step: each new word chains off the one computed before it.
    assign f0 = w0 ^ sub_word(rot_word(w3)) ^ rc_word;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    // Backward step undoes the chain from the last word; w0 needs the
    // recovered previous w3 (b3), so b3 must be formed first.
    assign b3 = w3 ^ w2;
    assign b2 = w2 ^ w1;
    assign b1 = w1 ^ w0;
    assign b0 = w0 ^ sub_word(rot_word(b3)) ^ rc_word;

    assign back_key  = {b0, b1, b2, b3};
    assign round_key = key_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
        end else if (load) begin
            key_q <= key_in;
        end else if (expand) begin
            key_q <= {f0, f1, f2, f3};
        end else if (step_back) begin
            key_q <= back_key;
        end
    end

endmodule

// File: rtl/aes_decrypt_top.sv
// aes_decrypt_top: iterative AES-128 inverse cipher.
//   clk             - clock, rising edge
//   rst             - synchronous active-high reset
//   start           - launches a decryption when sampled in IDLE or DONE
//   cipher_text     - ciphertext, sampled on the start cycle
//   cipher_key      - cipher key, sampled on the start cycle
//   done            - high while in DONE
//   completed_round - thermometer, bit r-1 set once inverse round r is done
//   plain_text      - result, updated on entry to DONE and held otherwise
// Parameter N (1,2,4,8,16) is the number of inverse S-box lanes; InvSubBytes
// takes 16/N cycles. Latency start->done is 20 + 10*(2 + 16/N) cycles.
module aes_decrypt_top
    import aes_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] cipher_text,
    input  logic [127:0] cipher_key,
    output logic         done,
    output logic [9:0]   completed_round,
    output logic [127:0] plain_text
);

    localparam int         ISB_CYCLES = 16 / N;
    localparam logic [3:0] ISB_LAST   = 4'(ISB_CYCLES - 1);
    localparam logic [3:0] KEXP_LAST  = 4'(ROUNDS - 1);
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    state_t       state_q, state_d;
    logic [127:0] data_q;
    logic [3:0]   cnt_q;
    logic [3:0]   round_q;
    logic [9:0]   completed_q;
    logic [127:0] plain_q;

    logic         launch;
    logic         key_fwd, key_back;
    logic [3:0]   rcon_idx;
    logic [127:0] round_key, back_key;
    logic [127:0] isb_data;
    logic [3:0]   isb_base;

    aes_inv_key_sched u_key_sched (
        .clk       (clk),
        .rst       (rst),
        .load      (launch),
        .expand    (key_fwd),
        .step_back (key_back),
        .rcon_idx  (rcon_idx),
        .key_in    (cipher_key),
        .round_key (round_key),
        .back_key  (back_key)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        key_fwd  = 1'b0;
        key_back = 1'b0;
        rcon_idx = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = ST_KEXP;
                end
            end
            ST_KEXP: begin
                key_fwd  = 1'b1;
                rcon_idx = cnt_q + 4'd1;
                if (cnt_q == KEXP_LAST) state_d = ST_INIT_AR;
            end
            ST_INIT_AR: state_d = ST_ISR;
            ST_ISR:     state_d = ST_ISB;
            ST_ISB: begin
                if (cnt_q == ISB_LAST) state_d = ST_KBACK;
            end
            ST_KBACK: begin
                key_back = 1'b1;
                // Inverse round r undoes forward round 11-r.
                rcon_idx = 4'(ROUNDS + 1) - round_q;
                state_d  = (round_q == LAST_ROUND) ? ST_DONE : ST_IMC;
            end
            ST_IMC:  state_d = ST_ISR;
            default: state_d = ST_IDLE;
        endcase
    end

    // N lanes per cycle over bytes base*N .. base*N+N-1. The mask keeps the
    // byte index in range while cnt_q is used as the KEXP counter.
    assign isb_base = cnt_q & ISB_LAST;

    always_comb begin
        isb_data = data_q;
        for (int l = 0; l < N; l++) begin
            isb_data[127 - 8*(int'(isb_base)*N + l) -: 8] =
                inv_sbox(data_q[127 - 8*(int'(isb_base)*N + l) -: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            cnt_q       <= '0;
            round_q     <= '0;
            completed_q <= '0;
            plain_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        data_q      <= cipher_text;
                        cnt_q       <= '0;
                        round_q     <= 4'd1;
                        completed_q <= '0;
                    end
                end
                ST_KEXP: begin
                    cnt_q <= (cnt_q == KEXP_LAST) ? 4'd0 : cnt_q + 4'd1;
                end
                ST_INIT_AR: begin
                    data_q <= data_q ^ round_key;
                end
                ST_ISR: begin
                    data_q <= inv_shift_rows(data_q);
                end
                ST_ISB: begin
                    data_q <= isb_data;
                    cnt_q  <= (cnt_q == ISB_LAST) ? 4'd0 : cnt_q + 4'd1;
                end
                ST_KBACK: begin
                    data_q <= data_q ^ back_key;
                    // The last round has no InvMixColumns, so it completes here.
                    if (round_q == LAST_ROUND) begin
                        completed_q <= {completed_q[8:0], 1'b1};
                        plain_q     <= data_q ^ back_key;
                    end
                end
                ST_IMC: begin
                    data_q      <= inv_mix_columns(data_q);
                    completed_q <= {completed_q[8:0], 1'b1};
                    round_q     <= round_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign done            = (state_q == ST_DONE);
    assign completed_round = completed_q;
    assign plain_text      = plain_q;

endmodule
